synth_i2s_tx: RTL

//   Audio back end of the synth. Generates the aud_freq sample-request strobe that drives synth.

---
 rtl/synth_pkg.sv | 24 ++
 rtl/synth_i2s_bclk_gen.sv | 37 +++
 rtl/synth_i2s_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth audio back end.
package synth_pkg;

  // Sample width produced by synth wave_out.
  localparam int unsigned SYNTH_BITWIDTH   = 24;
  localparam int unsigned SYNTH_SLOT_WIDTH = 32;
  localparam int unsigned SYNTH_BCLK_DIV   = 16;

  // I2S transmitter state encoding.
  typedef enum logic {
    I2S_IDLE = 1'b0,
    I2S_RUN  = 1'b1
  } i2s_state_e;

  // Slot position carrying the sample MSB for each framing format.
  localparam int unsigned I2S_STD_FIRST_POS = 1;  // standard I2S: one-BCLK delay
  localparam int unsigned I2S_LJ_FIRST_POS  = 0;  // left-justified: MSB on lrclk edge

  // Slot position of the sample MSB for the selected format.
  function automatic int unsigned i2s_first_pos(input logic left_justified);
    return left_justified ? I2S_LJ_FIRST_POS : I2S_STD_FIRST_POS;
  endfunction

endpackage

// File: rtl/synth_i2s_bclk_gen.sv
// Bit-clock generator: divides clk down to BCLK and flags its edges.
// fall_tick_c/rise_tick_c are high in the cycle whose edge toggles bclk.
module synth_i2s_bclk_gen #(
  parameter int unsigned BCLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fall_tick_c,
  output logic rise_tick_c
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic             term_c;

  // Terminal count of the half-period divider.
  assign term_c      = run && (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign fall_tick_c = term_c && bclk;
  assign rise_tick_c = term_c && !bclk;

  // Divider and bclk toggle; held at zero while not running.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (term_c) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= DIV_W'(div_cnt + 1'b1);
    end
  end

endmodule

// File: rtl/synth_i2s_tx.sv
// Audio back end: requests one sample per frame from synth (aud_freq) and
// serialises it as a mono, L/R-duplicated I2S stream.
// Build option: SYNTH_I2S_TX_LEFT_JUSTIFIED_EN selects left-justified framing
// (MSB on the lrclk edge) instead of standard I2S (one-BCLK delay).
module synth_i2s_tx
  import synth_pkg::*;
#(
  parameter int unsigned BITWIDTH   = SYNTH_BITWIDTH,
  parameter int unsigned SLOT_WIDTH = SYNTH_SLOT_WIDTH,
  parameter int unsigned BCLK_DIV   = SYNTH_BCLK_DIV
) (
  input  logic                ctl_clk,
  input  logic                ctl_rst,
  input  logic                enable,
  input  logic [BITWIDTH-1:0] wave_in,
  output logic                aud_freq,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                busy
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int unsigned IDX_W      = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;
`ifdef SYNTH_I2S_TX_LEFT_JUSTIFIED_EN
  localparam logic        LJ_BUILD   = 1'b1;
`else
  localparam logic        LJ_BUILD   = 1'b0;
`endif
  localparam int unsigned FIRST_POS  = i2s_first_pos(LJ_BUILD);

  i2s_state_e             state, state_next;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_next, bit_inc;
  logic [BITWIDTH-1:0]    tx_sample, tx_sample_next;
  logic                   aud_freq_next, lrclk_next, sdata_next, busy_next;
  logic                   run_c, fall_tick_c, rise_tick_c;

  // Serial bit for frame position cnt of sample s (zero padding outside data).
  // A position before FIRST_POS wraps to a large offset and falls outside.
  function automatic logic slot_bit(input logic [BITWIDTH-1:0] s,
                                    input logic [BIT_CNT_W-1:0] cnt);
    logic [BIT_CNT_W-1:0] p;
    logic [BIT_CNT_W-1:0] off;
    logic [IDX_W-1:0]     idx;
    slot_bit = 1'b0;
    p   = (cnt >= BIT_CNT_W'(SLOT_WIDTH)) ? BIT_CNT_W'(cnt - BIT_CNT_W'(SLOT_WIDTH)) : cnt;
    off = BIT_CNT_W'(p - BIT_CNT_W'(FIRST_POS));
    idx = IDX_W'(IDX_W'(BITWIDTH - 1) - IDX_W'(off));
    if (off < BIT_CNT_W'(BITWIDTH)) begin
      slot_bit = s[idx];
    end
  endfunction

  assign run_c = (state == I2S_RUN);

  synth_i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk         (ctl_clk),
    .rst         (ctl_rst),
    .run         (run_c),
    .bclk        (i2s_bclk),
    .fall_tick_c (fall_tick_c),
    .rise_tick_c (rise_tick_c)
  );

  // Next-state, frame counter, sample load and serial output selection.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    tx_sample_next = tx_sample;
    aud_freq_next  = 1'b0;
    lrclk_next     = i2s_lrclk;
    sdata_next     = i2s_sdata;
    busy_next      = busy;
    bit_inc        = BIT_CNT_W'(bit_cnt + 1'b1);
    case (state)
      I2S_IDLE: begin
        bit_cnt_next = '0;
        lrclk_next   = 1'b0;
        sdata_next   = 1'b0;
        busy_next    = 1'b0;
        if (enable) begin
          state_next     = I2S_RUN;
          aud_freq_next  = 1'b1;
          tx_sample_next = wave_in;
          sdata_next     = slot_bit(wave_in, '0);
          busy_next      = 1'b1;
        end
      end
      I2S_RUN: begin
        if (fall_tick_c) begin
          if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
            bit_cnt_next = '0;
            lrclk_next   = 1'b0;
            if (enable) begin
              aud_freq_next  = 1'b1;
              tx_sample_next = wave_in;
              sdata_next     = slot_bit(wave_in, '0);
            end else begin
              state_next = I2S_IDLE;
              sdata_next = 1'b0;
              busy_next  = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_inc;
            lrclk_next   = (bit_inc >= BIT_CNT_W'(SLOT_WIDTH));
            sdata_next   = slot_bit(tx_sample, bit_inc);
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge ctl_clk) begin
    if (ctl_rst) begin
      state     <= I2S_IDLE;
      bit_cnt   <= '0;
      tx_sample <= '0;
      aud_freq  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      tx_sample <= tx_sample_next;
      aud_freq  <= aud_freq_next;
      i2s_lrclk <= lrclk_next;
      i2s_sdata <= sdata_next;
      busy      <= busy_next;
    end
  end

  // BCLK rising and falling strobes never coincide.
  assert property (@(posedge ctl_clk) disable iff (ctl_rst) !(fall_tick_c && rise_tick_c));

endmodule
